cic_int_comb: RTL
=================

# cic_int_comb

Transmit-path comb cascade of the CIC interpolator, the counterpart to the decimation comb on the receive path. It accepts signed audio-rate samples on a valid/ready handshake at `clk_div` and applies an optional `os_sel`-controlled pre-attenuation. It then runs NS pipelined first-difference stages and presents the bit-grown result to the upsampler/integrator section. That section uses `flag_out` as the sample-phase and sign marker.

## Interface

- IDW, 16: input sample width, signed two's complement
- NS, 3: number of comb stages, 1..6
- ODW, IDW+NS: output width; must equal IDW+NS

- clk_div  in  1  sample-rate clock; reset reset_n, asynchronous, active-low; clock clk_div
- reset_n  in  1  asynchronous active-low reset
- os_sel  in  3  001..110 enable with pre-shift of os_sel-1 bits; 000/111 disable
- in_valid  in  1  data_in holds a sample
- in_ready  out  1  block accepts a sample this cycle
- data_in  in  IDW  signed input sample
- out_valid  out  1  data_out/flag_out hold a sample
- out_ready  in  1  downstream accepts the sample
- data_out  out  ODW  signed comb output
- flag_out  out  2  [0] toggles on every new output sample; [1] sign of data_out

## Operation

- Enabled when os_sel ∈ {001..110}; otherwise disabled.
- Stall control: en = out_ready | ~out_valid. in_ready = en & enabled.
- Accept: a transfer occurs when in_valid & in_ready.
- Stage 0 (prescale): p = data_in arithmetically shifted right by sh = os_sel-1, rounded half-up: (data_in + 2^(sh-1)) >>> sh for sh>0. The result saturates to IDW-bit signed max on positive overflow. Example: 32767 at sh=1 gives 16384.
- Stage k, 1..NS: width IDW+k. Output s_k = s_(k-1) - d_k, with d_k holding the last valid s_(k-1) that entered stage k.
  - d_k updates only when a valid sample advances into stage k. Bubbles never update comb state.
- Arithmetic: each stage sign-extends by 1 bit. With ODW = IDW+NS, overflow cannot occur and no saturation is applied at the output.
- Pipeline: per-stage valid bits. All stages advance only when en=1. Bubbles propagate as invalid.
- Output register: data_out = s_NS. On each new valid output, flag_out[0] toggles and flag_out[1] = data_out[ODW-1].
- Disable (os_sel → 000/111): on the next clock edge, all valid bits, d_k, data registers, data_out and flag_out clear to 0. in_ready=0 while disabled.
- os_sel change between two nonzero values: no flush. The new shift applies to the next accepted sample. Samples already in flight keep their shift.

## Timing

- Reset values: in_ready=0, out_valid=0, data_out=0, flag_out=2'b00, all d_k=0, all stage valids=0.
- First in_ready=1 one cycle after reset release, given enabled.
- Latency without stall: a sample accepted at edge N appears with out_valid=1 after edge N+NS+1.
- Throughput: 1 sample/cycle when out_ready is held high.
- Backpressure: out_valid=1 & out_ready=0 holds data_out/flag_out stable and freezes all stages. in_ready=0 the same cycle, combinationally from out_ready.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: output consumed and input accepted in the same cycle, with no loss and no duplication.
- Reset asserted mid-stream: immediate clear to reset values. Samples in flight are discarded.
- Disable and in_valid in the same cycle: sample not accepted, because in_ready is already 0.

## Test plan

- Impulse, os_sel=001, NS=3: input 100 then zeros, out_ready=1 → outputs 100, -300, 300, -100, 0, 0. flag_out[0] toggles each sample; first output appears 4 cycles after acceptance.
- Step with rounding:
  - os_sel=011, constant 1000 → 250, -500, 250, 0, 0.
  - os_sel=010, input -3 → prescaled -1.
- Full-scale alternating: os_sel=001, input +32767/-32768 repeating → steady-state ±262140, with no wrap and correct flag_out[1] sign.
- Backpressure: stream 1..20 with out_ready low for 5 cycles mid-stream → in_ready drops the same cycle, data_out held stable, and the output sequence matches the unstalled reference exactly.
- Bubbles: in_valid pattern 1,0,0,1 carrying impulse 100 → outputs are identical to the dense case (100, -300, ...), proving d_k is unchanged by bubbles.
- Disable/reset mid-stream: os_sel→000 with 3 samples in flight → next cycle out_valid=0 and flag_out=00. Re-enable with input 50 → first output 50, proving history was cleared. Repeat with reset_n pulsed low.

Source files
------------

// File: rtl/cic_int_comb.sv
// cic_int_comb: transmit-path CIC comb cascade.
// Accepts signed samples on a valid/ready handshake, applies an optional
// rounded pre-attenuation selected by os_sel, runs NS first-difference
// stages and hands the bit-grown result to the upsampler/integrator.
module cic_int_comb #(
    parameter int IDW = 16,
    parameter int NS  = 3,
    parameter int ODW = IDW + NS
) (
    input  logic                  clk_div,
    input  logic                  reset_n,
    input  logic [2:0]            os_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [IDW-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [ODW-1:0] data_out,
    output logic [1:0]            flag_out
);

    localparam logic signed [IDW:0] SAT_MAX = {2'b00, {(IDW-1){1'b1}}};
    localparam logic signed [IDW:0] SAT_MIN = {2'b11, {(IDW-1){1'b0}}};

    // Clamp a one-bit-grown value back into the IDW-bit signed range.
    function automatic logic signed [IDW-1:0] f_sat(input logic signed [IDW:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[IDW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[IDW-1:0];
        end else begin
            return v[IDW-1:0];
        end
    endfunction

    // Arithmetic right shift by sh with round-half-up, then saturate.
    function automatic logic signed [IDW-1:0] f_prescale(input logic signed [IDW-1:0] x,
                                                         input logic [2:0]            sh);
        logic signed [IDW:0] v_ext;
        logic signed [IDW:0] v_rnd;
        logic signed [IDW:0] v_sum;
        if (sh == 3'd0) begin
            return x;
        end
        v_ext = {x[IDW-1], x};
        v_rnd = {{IDW{1'b0}}, 1'b1} << (sh - 3'd1);
        v_sum = v_ext + v_rnd;
        return f_sat(v_sum >>> sh);
    endfunction

    logic                  w_enabled;
    logic                  w_en;
    logic                  w_acc;
    logic [2:0]            w_sh;
    logic signed [IDW-1:0] w_pre;

    logic                  r_run;
    // Index 0 is the prescale register, index k the output of comb stage k.
    // Stage k only ever needs IDW+k bits; the upper bits are sign copies.
    logic                  r_vld_pk [0:NS];
    logic signed [ODW-1:0] r_s_pk   [0:NS];
    logic signed [ODW-1:0] r_d_pk   [1:NS];

    logic                  r_out_valid;
    logic signed [ODW-1:0] r_data_out;
    logic [1:0]            r_flag_out;

    assign w_enabled = (os_sel != 3'b000) && (os_sel != 3'b111);
    assign w_en      = out_ready | ~r_out_valid;
    assign in_ready  = w_en & w_enabled & r_run;
    assign w_acc     = in_valid & in_ready;
    assign w_sh      = os_sel - 3'd1;
    assign w_pre     = f_prescale(data_in, w_sh);

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign flag_out  = r_flag_out;

    // Keep in_ready low for the first cycle after reset is released.
    always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Prescale register and comb cascade; history moves only with valid samples.
    always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= NS; k++) begin
                r_vld_pk[k] <= 1'b0;
                r_s_pk[k]   <= '0;
            end
            for (int k = 1; k <= NS; k++) begin
                r_d_pk[k] <= '0;
            end
        end else if (!w_enabled) begin
            for (int k = 0; k <= NS; k++) begin
                r_vld_pk[k] <= 1'b0;
                r_s_pk[k]   <= '0;
            end
            for (int k = 1; k <= NS; k++) begin
                r_d_pk[k] <= '0;
            end
        end else if (w_en) begin
            // stage 0: prescale
            r_vld_pk[0] <= w_acc;
            if (w_acc) begin
                r_s_pk[0] <= {{(ODW-IDW){w_pre[IDW-1]}}, w_pre};
            end
            // stages 1..NS: first differences
            for (int k = 1; k <= NS; k++) begin
                r_vld_pk[k] <= r_vld_pk[k-1];
                if (r_vld_pk[k-1]) begin
                    r_s_pk[k] <= r_s_pk[k-1] - r_d_pk[k];
                    r_d_pk[k] <= r_s_pk[k-1];
                end
            end
        end
    end

    // Output register: phase toggle and sign marker update with each new sample.
    always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_flag_out  <= 2'b00;
        end else if (!w_enabled) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_flag_out  <= 2'b00;
        end else if (w_en) begin
            r_out_valid <= r_vld_pk[NS];
            if (r_vld_pk[NS]) begin
                r_data_out <= r_s_pk[NS];
                r_flag_out <= {r_s_pk[NS][ODW-1], ~r_flag_out[0]};
            end
        end
    end

endmodule
